dvp_pattern_gen: RTL and testbench
==================================

# dvp_pattern_gen

Synthetic DVP image source. It generates sensor-style frame timing (vsync, href, 8-bit data) and a selectable test pattern, and drives the same interface that the crop and scale stages consume. It replaces the CMOS sensor during bring-up and regression, so downstream crop, scale and LVDS stages can be exercised with deterministic pixel content.

## Interface
- IMAGE_HSIZE, 1280: active pixels per line (1..4095)
- IMAGE_VSIZE, 1024: active lines per frame (1..4095)
- H_BLANK, 160: href-low clocks between consecutive lines (≥1)
- V_SYNC, 16: vsync-low clocks at frame start (≥1)
- V_FRONT, 8: vsync-high clocks before the first line (≥1)
- V_BACK, 8: vsync-high clocks after the last line (≥1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; 1 = generate frames
- pattern_sel  in  2  0 horizontal ramp, 1 vertical ramp, 2 moving diagonal, 3 checkerboard
- image_out_vsync  out  1  H = frame valid, L = frame sync
- image_out_href  out  1  H = pixel valid, L = line sync
- image_out_data  out  8  pixel data; 0 whenever href is low
- frame_cnt  out  8  completed-frame counter, wraps at 255→0
- busy  out  1  high from leaving IDLE until returning to IDLE

## Operation
- FSM states: IDLE, VS, VF, LINE, HB, VB.
- IDLE: if enable=1, go to VS.
- VS: run V_SYNC clocks, then go to VF.
- VF: run V_FRONT clocks, then go to LINE.
- LINE: run IMAGE_HSIZE clocks. Go to HB if ypos < IMAGE_VSIZE-1, otherwise go to VB.
- HB: run H_BLANK clocks, then go to LINE with ypos+1.
- VB: run V_BACK clocks. frame_cnt increments on the last VB clock. Then go to VS if enable=1, otherwise to IDLE.
- Output decode:
  - vsync = 1 in VF, LINE, HB and VB.
  - href = 1 only in LINE.
  - busy = 1 in every state except IDLE.
- enable is sampled only in IDLE and on the last VB clock. Deasserting it mid-frame lets the current frame complete; a frame is never truncated.
- pattern_sel is latched on entry to VS and held constant for the whole frame.
- Pixel data uses xpos (0..IMAGE_HSIZE-1 within a line), ypos (0..IMAGE_VSIZE-1) and latched frame_cnt:
  - p0: xpos[7:0]
  - p1: ypos[7:0]
  - p2: (xpos+ypos+frame_cnt)[7:0]
  - p3: (xpos[3]^ypos[3]) ? 8'hFF : 8'h00
- Counters are 12 bits wide and the sums are truncated to 8 bits.
- xpos resets to 0 in every non-LINE state. ypos resets to 0 in VS.

## Timing
- All outputs are registered.
- Reset values: vsync 0, href 0, data 0, frame_cnt 0, busy 0, state IDLE.
- Asynchronous reset mid-frame returns the block to IDLE immediately. Outputs go to their reset values with no partial-frame completion.
- Cycle 0 is the edge where enable=1 is sampled in IDLE:
  - busy=1 and vsync=0 from cycle 1.
  - vsync rises at cycle 1+V_SYNC.
  - First href rises at cycle 1+V_SYNC+V_FRONT, with data for xpos=0 in the same cycle.
- Data is valid in the same cycle as href. Ramps advance by one per clock with no gaps inside a line.
- Frame length (VS entry to next VS entry) is V_SYNC+V_FRONT+IMAGE_VSIZE·IMAGE_HSIZE+(IMAGE_VSIZE-1)·H_BLANK+V_BACK clocks.
- With enable held high, frames are back-to-back with no IDLE cycle.
- The frame_cnt update is visible in the cycle after the last VB clock, coincident with VS entry or busy falling.

## Test plan
- Reset with enable=0 → all outputs 0, busy 0 for 100 clocks.
- Parameters HSIZE=8, VSIZE=4, H_BLANK=3, V_SYNC=2, V_FRONT=2, V_BACK=2, p0, enable pulsed for one clock → exactly one frame of 47 clocks:
  - vsync low for 2 clocks, then high for 45.
  - 4 href pulses, each 8 clocks long with 3-clock gaps, data 0..7 per line.
  - Then IDLE, frame_cnt=1.
- Same parameters, enable held high, p1 → back-to-back 47-clock frames; line n carries data n for all 8 pixels; frame_cnt counts 1,2,3.
- p2 over 3 frames → frame k, line y, pixel x carries (x+y+k) mod 256; pattern_sel changed mid-frame has no effect until the next VS.
- p3 with HSIZE=16, VSIZE=16:
  - Pixels 0..7 on lines 0..7 → 00.
  - Pixels 8..15 on lines 0..7 → FF.
  - Both are inverted on lines 8..15.
  - 256 frames → frame_cnt wraps to 0.
- rst_n asserted during LINE of frame 1 → outputs 0 and busy 0 within the same cycle; after release with enable=1, a full frame restarts from VS with frame_cnt=0.

Source files
------------

// File: rtl/dvp_pattern_gen.sv
// Synthetic DVP frame source: sensor-style vsync/href timing with a selectable
// 8-bit test pattern, replacing the CMOS sensor ahead of crop/scale/LVDS.
module dvp_pattern_gen #(
   parameter int unsigned IMAGE_HSIZE = 1280,
   parameter int unsigned IMAGE_VSIZE = 1024,
   parameter int unsigned H_BLANK     = 160,
   parameter int unsigned V_SYNC      = 16,
   parameter int unsigned V_FRONT     = 8,
   parameter int unsigned V_BACK      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       image_out_vsync,
   output logic       image_out_href,
   output logic [7:0] image_out_data,
   output logic [7:0] frame_cnt,
   output logic       busy
);

   localparam logic [11:0] HS_LAST = 12'(IMAGE_HSIZE - 1);
   localparam logic [11:0] VS_LAST = 12'(IMAGE_VSIZE - 1);
   localparam logic [11:0] HB_LAST = 12'(H_BLANK - 1);
   localparam logic [11:0] SY_LAST = 12'(V_SYNC - 1);
   localparam logic [11:0] VF_LAST = 12'(V_FRONT - 1);
   localparam logic [11:0] VB_LAST = 12'(V_BACK - 1);

   typedef enum logic [2:0] {
      IDLE,
      VS,
      VF,
      LINE,
      HB,
      VB
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [11:0] cnt;
   logic [11:0] cnt_nxt;
   logic [11:0] ypos;
   logic [11:0] ypos_nxt;
   logic [7:0]  frame_cnt_nxt;
   logic [7:0]  frame_lat;
   logic [1:0]  pat_lat;
   logic        last;
   logic [7:0]  pix;

   // cnt is the clock count within the current state; in LINE it is xpos.
   always_comb begin
      state_nxt = state;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (enable) state_nxt = VS;
         end
         VS: begin
            last = (cnt == SY_LAST);
            if (last) state_nxt = VF;
         end
         VF: begin
            last = (cnt == VF_LAST);
            if (last) state_nxt = LINE;
         end
         LINE: begin
            last = (cnt == HS_LAST);
            if (last) state_nxt = (ypos == VS_LAST) ? VB : HB;
         end
         HB: begin
            last = (cnt == HB_LAST);
            if (last) state_nxt = LINE;
         end
         VB: begin
            last = (cnt == VB_LAST);
            if (last) state_nxt = enable ? VS : IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if ((state_nxt != state) || (state_nxt == IDLE)) cnt_nxt = '0;
      else cnt_nxt = cnt + 12'd1;

      if (state_nxt == VS) ypos_nxt = '0;
      else if ((state == HB) && (state_nxt == LINE)) ypos_nxt = ypos + 12'd1;
      else ypos_nxt = ypos;

      if ((state == VB) && last) frame_cnt_nxt = frame_cnt + 8'd1;
      else frame_cnt_nxt = frame_cnt;

      // Pixel is computed from next-cycle coordinates so data lands with href.
      case (pat_lat)
         2'd0:    pix = cnt_nxt[7:0];
         2'd1:    pix = ypos_nxt[7:0];
         2'd2:    pix = cnt_nxt[7:0] + ypos_nxt[7:0] + frame_lat;
         default: pix = {8{cnt_nxt[3] ^ ypos_nxt[3]}};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         ypos            <= '0;
         frame_cnt       <= '0;
         frame_lat       <= '0;
         pat_lat         <= '0;
         busy            <= 1'b0;
         image_out_vsync <= 1'b0;
         image_out_href  <= 1'b0;
         image_out_data  <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ypos      <= ypos_nxt;
         frame_cnt <= frame_cnt_nxt;
         if ((state_nxt == VS) && (state != VS)) begin
            pat_lat   <= pattern_sel;
            frame_lat <= frame_cnt_nxt;
         end
         busy            <= (state_nxt != IDLE);
         image_out_vsync <= (state_nxt != IDLE) && (state_nxt != VS);
         image_out_href  <= (state_nxt == LINE);
         image_out_data  <= (state_nxt == LINE) ? pix : 8'h00;
      end
   end

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Self-checking bench for dvp_pattern_gen: per-cycle comparison of two small
// instances against a frame-stream model built from the timing rules.
module tb_dvp_pattern_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en_a = 1'b0, en_b = 1'b0;
   logic [1:0] sel_a = '0, sel_b = '0;
   logic       vs_a, hr_a, bz_a, vs_b, hr_b, bz_b;
   logic [7:0] dt_a, fc_a, dt_b, fc_b;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   dvp_pattern_gen #(
      .IMAGE_HSIZE(8), .IMAGE_VSIZE(4), .H_BLANK(3),
      .V_SYNC(2), .V_FRONT(2), .V_BACK(2)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(en_a), .pattern_sel(sel_a),
      .image_out_vsync(vs_a), .image_out_href(hr_a), .image_out_data(dt_a),
      .frame_cnt(fc_a), .busy(bz_a)
   );

   dvp_pattern_gen #(
      .IMAGE_HSIZE(16), .IMAGE_VSIZE(16), .H_BLANK(3),
      .V_SYNC(2), .V_FRONT(2), .V_BACK(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(en_b), .pattern_sel(sel_b),
      .image_out_vsync(vs_b), .image_out_href(hr_b), .image_out_data(dt_b),
      .frame_cnt(fc_b), .busy(bz_b)
   );

   function automatic logic [7:0] model_pix(int p, int x, int y, int k);
      case (p)
         0:       return 8'(x % 256);
         1:       return 8'(y % 256);
         2:       return 8'((x + y + k) % 256);
         default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      endcase
   endfunction

   // Compares one whole frame cycle by cycle; first @(negedge) is the first VS cycle.
   // On the final VB cycle it drives the enable/pattern seen at the frame boundary.
   task automatic check_frame(input int d, input int k, input int p,
                              input int next_p, input bit next_en, input bit scramble);
      logic [9:0]  q[$];
      logic [18:0] obs, expv;
      int hs, vsz;
      hs  = d ? 16 : 8;
      vsz = d ? 16 : 4;
      q.delete();
      repeat (2) q.push_back(10'h000);
      repeat (2) q.push_back(10'h200);
      for (int y = 0; y < vsz; y++) begin
         for (int x = 0; x < hs; x++) q.push_back({2'b11, model_pix(p, x, y, k)});
         if (y < vsz - 1) repeat (3) q.push_back(10'h200);
      end
      repeat (2) q.push_back(10'h200);
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         obs  = d ? {bz_b, vs_b, hr_b, dt_b, fc_b} : {bz_a, vs_a, hr_a, dt_a, fc_a};
         expv = {1'b1, q[i], 8'(k)};
         n_total++;
         if (obs !== expv)
            $display("FAIL frame dut%0d k=%0d p=%0d cyc=%0d {busy,vs,href,data,fc} got=%h exp=%h",
                     d, k, p, i, obs, expv);
         else n_pass++;
         if (i == q.size() - 1) begin
            if (d) begin en_b = next_en; sel_b = 2'(next_p); end
            else   begin en_a = next_en; sel_a = 2'(next_p); end
         end else if (scramble) begin
            if (d) begin en_b = 1'($urandom); sel_b = 2'($urandom); end
            else   begin en_a = 1'($urandom); sel_a = 2'($urandom); end
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_total++;
      if ({bz_a, vs_a, hr_a, dt_a, fc_a, bz_b, vs_b, hr_b, dt_b, fc_b} !== '0)
         $display("FAIL reset_hold got=%h exp=0", {bz_a, vs_a, hr_a, dt_a, fc_a});
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n_total++;
         if ({bz_a, vs_a, hr_a, dt_a, fc_a, bz_b, vs_b, hr_b, dt_b, fc_b} !== '0)
            $display("FAIL reset_idle cyc=%0d got_a=%h got_b=%h exp=0", i,
                     {bz_a, vs_a, hr_a, dt_a, fc_a}, {bz_b, vs_b, hr_b, dt_b, fc_b});
         else n_pass++;
      end
   endtask

   task automatic test_single_frame;
      sel_a = 2'd0;
      en_a  = 1'b1;
      check_frame(0, 0, 0, 0, 1'b0, 1'b1);
      repeat (2) begin
         @(negedge clk);
         n_total++;
         if ({bz_a, vs_a, hr_a, dt_a, fc_a} !== {11'h0, 8'd1})
            $display("FAIL single_idle got=%h exp=%h", {bz_a, vs_a, hr_a, dt_a, fc_a}, {11'h0, 8'd1});
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      sel_a = 2'd1;
      en_a  = 1'b1;
      check_frame(0, 1, 1, 1, 1'b1, 1'b0);
      check_frame(0, 2, 1, 1, 1'b1, 1'b0);
      check_frame(0, 3, 1, 2, 1'b1, 1'b0);
   endtask

   task automatic test_diagonal;
      check_frame(0, 4, 2, 2, 1'b1, 1'b1);
      check_frame(0, 5, 2, 2, 1'b1, 1'b1);
      check_frame(0, 6, 2, 0, 1'b0, 1'b1);
      @(negedge clk);
      n_total++;
      if ({bz_a, vs_a, hr_a, dt_a, fc_a} !== {11'h0, 8'd7})
         $display("FAIL diag_idle got=%h exp=%h", {bz_a, vs_a, hr_a, dt_a, fc_a}, {11'h0, 8'd7});
      else n_pass++;
   endtask

   task automatic test_checker_wrap;
      int cur_p, nxt_p;
      cur_p = 3;
      sel_b = 2'd3;
      en_b  = 1'b1;
      for (int k = 0; k < 256; k++) begin
         nxt_p = (k < 1) ? 3 : int'($urandom_range(0, 3));
         check_frame(1, k, cur_p, nxt_p, (k != 255), 1'b1);
         cur_p = nxt_p;
      end
      @(negedge clk);
      n_total++;
      if ({bz_b, vs_b, hr_b, dt_b, fc_b} !== 19'h0)
         $display("FAIL wrap_idle got=%h exp=0", {bz_b, vs_b, hr_b, dt_b, fc_b});
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame;
      sel_a = 2'd0;
      en_a  = 1'b1;
      repeat (8) @(negedge clk);
      n_total++;
      if ({bz_a, vs_a, hr_a} !== 3'b111)
         $display("FAIL mid_in_line got=%b exp=111", {bz_a, vs_a, hr_a});
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({bz_a, vs_a, hr_a, dt_a, fc_a} !== 19'h0)
         $display("FAIL mid_reset got=%h exp=0", {bz_a, vs_a, hr_a, dt_a, fc_a});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      en_a  = 1'b1;
      check_frame(0, 0, 0, 0, 1'b0, 1'b1);
      @(negedge clk);
      n_total++;
      if ({bz_a, vs_a, hr_a, dt_a, fc_a} !== {11'h0, 8'd1})
         $display("FAIL restart_idle got=%h exp=%h", {bz_a, vs_a, hr_a, dt_a, fc_a}, {11'h0, 8'd1});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_diagonal();
      test_checker_wrap();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
